// File: rtl/pkg_parking.sv
// Shared types and constants for the parking slot-occupancy engine.
// Imported by the bitmap/counter block and the request FSM.
package pkg_parking;

    localparam int PARKING_SLOTS = 16;

    typedef enum logic [1:0] {
        OP_ENTRY = 2'd0,
        OP_EXIT  = 2'd1,
        OP_QUERY = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        RSP_OK       = 2'd0,
        RSP_OCCUPIED = 2'd1,
        RSP_VACANT   = 2'd2,
        RSP_REJECT   = 2'd3
    } rsp_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Slot index width, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/slot_bitmap_ctr.sv
// Per-slot occupancy bitmap with a live occupied-slot count and registered full/empty flags.
// A single index serves both the read port and the set/clear commands.
module slot_bitmap_ctr
    import pkg_parking::*;
#(
    parameter int N_SLOTS = PARKING_SLOTS,
    parameter int ID_W    = id_width(N_SLOTS),
    parameter int CNT_W   = $clog2(N_SLOTS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ID_W-1:0]  idx_i,
    output logic             idx_valid_o,
    output logic             occupied_o,
    input  logic             set_i,
    input  logic             clr_i,
    input  logic             clear_all_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [ID_W:0]    IDX_LIMIT = (ID_W + 1)'(N_SLOTS);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(N_SLOTS);

    logic [N_SLOTS-1:0] bitmap_q, bitmap_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, empty_q;

    assign idx_valid_o = ({1'b0, idx_i} < IDX_LIMIT);
    assign occupied_o  = idx_valid_o ? bitmap_q[idx_i] : 1'b0;

    // Count moves only on real bit transitions, so it can never leave 0..N_SLOTS.
    always_comb begin
        // NOTE: every signal written here gets a default first; a missing branch would otherwise infer a latch.
        bitmap_d = bitmap_q;
        count_d  = count_q;
        if (clear_all_i) begin
            bitmap_d = '0;
            count_d  = '0;
        end else if (set_i && idx_valid_o && !bitmap_q[idx_i]) begin
            bitmap_d[idx_i] = 1'b1;
            count_d         = count_q + CNT_W'(1);
        end else if (clr_i && idx_valid_o && bitmap_q[idx_i]) begin
            bitmap_d[idx_i] = 1'b0;
            count_d         = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the bitmap is a handful of flops, not a RAM, so it is reset along with everything else.
            bitmap_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            bitmap_q <= bitmap_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_FULL);
            empty_q  <= (count_d == '0);
        end
    end

    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/slot_occupancy_tracker.sv
// Slot-availability engine: request FSM (IDLE -> EVAL -> RESP) with valid/ready on both sides,
// driving the occupancy bitmap/counter that sits between password check and gate control.
module slot_occupancy_tracker
    import pkg_parking::*;
#(
    parameter int N_SLOTS = PARKING_SLOTS,
    parameter int ID_W    = id_width(N_SLOTS),
    parameter int CNT_W   = $clog2(N_SLOTS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic             req_pwd_ok,
    input  logic [ID_W-1:0]  req_slot,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_code,
    output logic [ID_W-1:0]  rsp_slot,
    input  logic             clear_all,
    output logic [CNT_W-1:0] occ_count,
    output logic             full,
    output logic             empty
);

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic            pwd_q, pwd_d;
    logic [ID_W-1:0] slot_q, slot_d;
    rsp_code_e       code_q, code_d;

    logic slot_valid, slot_occ;
    logic set_cmd, clr_cmd, clear_cmd;

    slot_bitmap_ctr #(
        .N_SLOTS (N_SLOTS),
        .ID_W    (ID_W),
        .CNT_W   (CNT_W)
    ) u_bitmap (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx_i       (slot_q),
        .idx_valid_o (slot_valid),
        .occupied_o  (slot_occ),
        .set_i       (set_cmd),
        .clr_i       (clr_cmd),
        .clear_all_i (clear_cmd),
        .count_o     (occ_count),
        .full_o      (full),
        .empty_o     (empty)
    );

    // clear_all wins over acceptance, so ready drops for the clear cycle.
    assign req_ready = rst_n && (state_q == ST_IDLE) && !clear_all;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_code  = code_q;
    assign rsp_slot  = slot_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        pwd_d     = pwd_q;
        slot_d    = slot_q;
        code_d    = code_q;
        set_cmd   = 1'b0;
        clr_cmd   = 1'b0;
        clear_cmd = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_all) begin
                    clear_cmd = 1'b1;
                end else if (req_valid) begin
                    op_d    = req_op;
                    pwd_d   = req_pwd_ok;
                    slot_d  = req_slot;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                state_d = ST_RESP;
                if (!slot_valid) begin
                    code_d = RSP_REJECT;
                end else begin
                    case (op_q)
                        OP_ENTRY: begin
                            if (!pwd_q) begin
                                code_d = RSP_REJECT;
                            end else if (slot_occ) begin
                                code_d = RSP_OCCUPIED;
                            end else begin
                                code_d  = RSP_OK;
                                set_cmd = 1'b1;
                            end
                        end
                        OP_EXIT: begin
                            if (slot_occ) begin
                                code_d  = RSP_OK;
                                clr_cmd = 1'b1;
                            end else begin
                                code_d = RSP_VACANT;
                            end
                        end
                        OP_QUERY: code_d = slot_occ ? RSP_OCCUPIED : RSP_OK;
                        default:  code_d = RSP_REJECT;
                    endcase
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            pwd_q   <= 1'b0;
            slot_q  <= '0;
            code_q  <= RSP_OK;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            pwd_q   <= pwd_d;
            slot_q  <= slot_d;
            code_q  <= code_d;
        end
    end

endmodule

// File: tb/tb_slot_occupancy_tracker.sv
// Directed scoreboard bench: an 8-slot instance for the main flow and a 6-slot instance
// for out-of-range slot rejection; expected codes come from a shadow occupancy model.
module tb_slot_occupancy_tracker;
    import pkg_parking::*;

    localparam int NA = 8;
    localparam int NB = 6;

    typedef struct packed {
        logic [1:0] code;
        logic [2:0] slot;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       sel_b = 1'b0;
    logic       drv_valid = 1'b0, drv_pwd = 1'b0, drv_rsp_ready = 1'b0;
    logic [1:0] drv_op = 2'd0;
    logic [2:0] drv_slot = 3'd0;
    logic       a_clear = 1'b0, b_clear = 1'b0;

    logic       a_req_ready, a_rsp_valid, a_full, a_empty;
    logic [1:0] a_code;
    logic [2:0] a_rsp_slot;
    logic [3:0] a_cnt;
    logic       b_req_ready, b_rsp_valid, b_full, b_empty;
    logic [1:0] b_code;
    logic [2:0] b_rsp_slot;
    logic [2:0] b_cnt;

    slot_occupancy_tracker #(.N_SLOTS(NA)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(drv_valid && !sel_b), .req_ready(a_req_ready),
        .req_op(drv_op), .req_pwd_ok(drv_pwd), .req_slot(drv_slot),
        .rsp_valid(a_rsp_valid), .rsp_ready(drv_rsp_ready && !sel_b),
        .rsp_code(a_code), .rsp_slot(a_rsp_slot),
        .clear_all(a_clear), .occ_count(a_cnt), .full(a_full), .empty(a_empty)
    );

    slot_occupancy_tracker #(.N_SLOTS(NB)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(drv_valid && sel_b), .req_ready(b_req_ready),
        .req_op(drv_op), .req_pwd_ok(drv_pwd), .req_slot(drv_slot),
        .rsp_valid(b_rsp_valid), .rsp_ready(drv_rsp_ready && sel_b),
        .rsp_code(b_code), .rsp_slot(b_rsp_slot),
        .clear_all(b_clear), .occ_count(b_cnt), .full(b_full), .empty(b_empty)
    );

    logic       m_req_ready, m_rsp_valid, m_full, m_empty;
    logic [1:0] m_code;
    logic [2:0] m_rsp_slot;
    logic [3:0] m_cnt;
    assign m_req_ready = sel_b ? b_req_ready : a_req_ready;
    assign m_rsp_valid = sel_b ? b_rsp_valid : a_rsp_valid;
    assign m_code      = sel_b ? b_code      : a_code;
    assign m_rsp_slot  = sel_b ? b_rsp_slot  : a_rsp_slot;
    assign m_cnt       = sel_b ? {1'b0, b_cnt} : a_cnt;
    assign m_full      = sel_b ? b_full      : a_full;
    assign m_empty     = sel_b ? b_empty     : a_empty;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];
    bit   model_occ[NA];
    int   model_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_a(input logic [1:0] op, input logic pwd, input logic [2:0] s);
        case (op)
            2'd0: begin
                if (!pwd) return 2'd3;
                if (model_occ[s]) return 2'd1;
                model_occ[s] = 1'b1;
                model_cnt++;
                return 2'd0;
            end
            2'd1: begin
                if (!model_occ[s]) return 2'd2;
                model_occ[s] = 1'b0;
                model_cnt--;
                return 2'd0;
            end
            2'd2:    return model_occ[s] ? 2'd1 : 2'd0;
            default: return 2'd3;
        endcase
    endfunction

    function automatic void model_clear();
        foreach (model_occ[i]) model_occ[i] = 1'b0;
        model_cnt = 0;
    endfunction

    // One full transaction: accept, check two-cycle latency, optional backpressure, handshake.
    task automatic txn(input logic [1:0] op, input logic pwd, input logic [2:0] slot,
                       input logic [1:0] exp_code, input int hold);
        exp_t e;
        int   n;
        sb.push_back('{code: exp_code, slot: slot});
        @(negedge clk);
        n = 0;
        while (!m_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", m_req_ready, 1);
        drv_op = op; drv_pwd = pwd; drv_slot = slot; drv_valid = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0;
        check("eval_rsp_valid", m_rsp_valid, 0);
        check("eval_req_ready", m_req_ready, 0);
        @(negedge clk);
        check("rsp_valid_t2", m_rsp_valid, 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", m_rsp_valid, 1);
            check("hold_rsp_code", m_code, sb[0].code);
            check("hold_req_ready", m_req_ready, 0);
        end
        e = sb.pop_front();
        check("rsp_code", m_code, e.code);
        check("rsp_slot", m_rsp_slot, e.slot);
        drv_rsp_ready = 1'b1;
        @(negedge clk);
        drv_rsp_ready = 1'b0;
        check("post_rsp_valid", m_rsp_valid, 0);
    endtask

    task automatic txn_a(input logic [1:0] op, input logic pwd, input logic [2:0] slot, input int hold);
        txn(op, pwd, slot, model_a(op, pwd, slot), hold);
        check("occ_count", m_cnt, model_cnt);
        check("empty", m_empty, model_cnt == 0);
        check("full", m_full, model_cnt == NA);
    endtask

    initial begin
        model_clear();
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_req_ready", m_req_ready, 0);
        check("rst_rsp_valid", m_rsp_valid, 0);
        check("rst_rsp_code", m_code, 0);
        check("rst_rsp_slot", m_rsp_slot, 0);
        check("rst_count", m_cnt, 0);
        check("rst_full", m_full, 0);
        check("rst_empty", m_empty, 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", m_req_ready, 1);

        txn_a(OP_ENTRY, 1'b1, 3'd3, 0);
        txn_a(OP_ENTRY, 1'b1, 3'd3, 0);
        txn_a(OP_ENTRY, 1'b0, 3'd4, 0);
        txn_a(OP_EXIT,  1'b0, 3'd5, 0);
        txn_a(OP_EXIT,  1'b0, 3'd3, 0);
        txn_a(OP_QUERY, 1'b0, 3'd3, 0);

        for (int s = 0; s < NA; s++) txn_a(OP_ENTRY, 1'b1, 3'(s), 0);
        txn_a(OP_QUERY, 1'b0, 3'd5, 0);

        // clear_all with a concurrent request: the clear wins and the request is not taken.
        @(negedge clk);
        a_clear = 1'b1;
        drv_op = OP_ENTRY; drv_pwd = 1'b1; drv_slot = 3'd1; drv_valid = 1'b1;
        #1 check("clear_req_ready", m_req_ready, 0);
        @(negedge clk);
        a_clear = 1'b0;
        drv_valid = 1'b0;
        model_clear();
        check("clear_count", m_cnt, 0);
        check("clear_empty", m_empty, 1);
        check("clear_full", m_full, 0);
        check("clear_no_accept", m_rsp_valid, 0);
        @(negedge clk);
        check("clear_no_rsp", m_rsp_valid, 0);
        check("clear_ready_back", m_req_ready, 1);

        txn_a(OP_ENTRY, 1'b1, 3'd2, 10);
        txn_a(OP_QUERY, 1'b0, 3'd2, 0);
        txn_a(2'd3,     1'b1, 3'd1, 0);

        // Reset while a response is pending drops it immediately.
        @(negedge clk);
        drv_op = OP_ENTRY; drv_pwd = 1'b1; drv_slot = 3'd6; drv_valid = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0;
        @(negedge clk);
        check("midrst_in_resp", m_rsp_valid, 1);
        check("midrst_count_pre", m_cnt, 2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", m_rsp_valid, 0);
        check("midrst_count", m_cnt, 0);
        check("midrst_empty", m_empty, 1);
        check("midrst_rsp_code", m_code, 0);
        check("midrst_req_ready", m_req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        check("midrst_no_rsp", m_rsp_valid, 0);
        check("midrst_ready", m_req_ready, 1);

        sel_b = 1'b1;
        txn(OP_ENTRY, 1'b1, 3'd7, 2'd3, 0);
        check("b_oob_count", m_cnt, 0);
        txn(OP_ENTRY, 1'b1, 3'd5, 2'd0, 0);
        check("b_count", m_cnt, 1);
        txn(OP_EXIT,  1'b0, 3'd6, 2'd3, 0);
        txn(2'd3,     1'b1, 3'd2, 2'd3, 0);
        check("b_count_final", m_cnt, 1);
        check("b_empty", m_empty, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
